imem_fetch_decoder: RTL and testbench
=====================================

IMEM_FETCH_DECODER -- requirements
Module: imem_fetch_decoder

Interface
REQ-001 SHALL have parameter START_ADDR, 32'h0, byte address of the first word read.
REQ-002 SHALL have parameter MAX_WORDS, 16, maximum words fetched per run (1..255).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run; ignored while busy=1.
REQ-006 SHALL have port imem_re  output  1  instruction-memory read strobe.
REQ-007 SHALL have port imem_raddr  output  32  word-aligned read byte address.
REQ-008 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_re=1.
REQ-009 SHALL have port dec_valid  output  1  decoded instruction available.
REQ-010 SHALL have port dec_ready  input  1  consumer accepts the decoded instruction.
REQ-011 SHALL have ports dec_pc[31:0], dec_opcode[6:0], dec_rd[4:0], dec_rs1[4:0], dec_rs2[4:0], dec_funct3[2:0], dec_funct7[6:0], dec_imm[31:0], dec_type[2:0], dec_illegal[0:0], all outputs describing the word at dec_pc.
REQ-012 SHALL have ports busy  output  1  run in progress; done  output  1  run finished.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, OUT, FIN.
REQ-014 IDLE: on start=1, load pc=START_ADDR, clear word count and done, set busy, go to REQ.
REQ-015 REQ: imem_re=1 for one cycle with imem_raddr=pc; go to WAIT; imem_re=0 in all other states.
REQ-016 WAIT: capture imem_rdata into instruction register, decode, go to OUT; dec_valid asserts the following cycle.
REQ-017 OUT: dec_valid=1 and all dec_* outputs SHALL hold stable until the dec_ready=1 cycle.
REQ-018 Handshake: transfer on dec_valid&dec_ready; dec_valid deasserts the next cycle; dec_ready while dec_valid=0 SHALL be ignored.
REQ-019 After transfer: if word==32'h0000006F (JAL x0,0) or count reaches MAX_WORDS, go to FIN; else pc+=4, go to REQ.
REQ-020 FIN: busy=0, done=1 (level), return to IDLE; done stays 1 until next accepted start.
REQ-021 Field slicing: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], always from the raw word.
REQ-022 dec_type: 0 R (0110011), 1 I-ALU (0010011), 2 LOAD (0000011), 3 STORE (0100011), 4 JAL (1101111), 7 other with dec_illegal=1.
REQ-023 dec_imm sign-extended to 32 bits: I/LOAD {[31:20]}; STORE {[31:25],[11:7]}; JAL {[31],[19:12],[20],[30:21],0}; R and illegal 0.
REQ-024 Minimum throughput: one word per 3 cycles with dec_ready held 1.
REQ-025 pc SHALL wrap modulo 2^32; no address fault.
REQ-026 start asserted the same cycle as the final transfer SHALL be ignored.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE, imem_re=0, imem_raddr=0, dec_valid=0, busy=0, done=0, count=0, all dec_* fields 0, from any state including mid-run.
REQ-028 No in-flight read data SHALL be presented after reset release.

Structure
REQ-029 Opcode constants (R, I, S, L, JAL), the dec_type encoding and the halt word 32'h0000006F SHALL live in a shared package, also used by instr_loader-side code.
REQ-030 A combinational sub-module rv_instr_decode (word in, fields/type/imm/illegal out) SHALL hold the decode; the FSM stays in the top module.

Verification
REQ-031 Memory holds 0x00500493 at 0 and 0x0000006F at 4; start -> dec_pc=0, type 1, rd 9, rs1 0, imm 5; then JAL type 4, imm 0; done=1 after two transfers.
REQ-032 Word 0x40A485B3 -> type 0, rd 11, rs1 9, rs2 10, funct7 0x20, funct3 0, imm 0.
REQ-033 Words 0x00B02223 and 0x00402603 -> STORE rs2 11 imm 4; LOAD rd 12 funct3 2 imm 4.
REQ-034 Word 0xFFF00493 -> imm 0xFFFFFFFF; word 0xFFFFFFFF -> type 7, dec_illegal=1.
REQ-035 dec_ready held 0 for 10 cycles in OUT -> outputs stable, no new imem_re; no halt word, MAX_WORDS=3 -> exactly 3 transfers then done.
REQ-036 rst=0 during WAIT -> next cycle dec_valid=0, busy=0; fresh start re-reads from START_ADDR.

Source files
------------

// File: rtl/imem_fetch_decoder_pkg.sv
// Shared definitions for the instruction fetch/decode path: RV32 opcode
// constants, the decoded-type encoding, the halt word and the FSM states.
// The loader side uses the same constants when building memory images.
package imem_fetch_decoder_pkg;

  localparam logic [6:0]  OPC_R     = 7'b0110011;
  localparam logic [6:0]  OPC_I     = 7'b0010011;
  localparam logic [6:0]  OPC_L     = 7'b0000011;
  localparam logic [6:0]  OPC_S     = 7'b0100011;
  localparam logic [6:0]  OPC_JAL   = 7'b1101111;

  // JAL x0,0 : a jump-to-self that marks the end of a program image
  localparam logic [31:0] HALT_WORD = 32'h0000006F;

  typedef enum logic [2:0] {
    DT_R     = 3'd0,
    DT_I     = 3'd1,
    DT_LOAD  = 3'd2,
    DT_STORE = 3'd3,
    DT_JAL   = 3'd4,
    DT_OTHER = 3'd7
  } dec_type_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_FIN  = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    dec_type_e   dtype;
    logic        illegal;
  } dec_fields_t;

  // Sign-extend a 12-bit immediate to 32 bits
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/imem_fetch_decoder_rv_instr_decode.sv
// Purely combinational RV32 decode of one raw instruction word into register
// fields, a coarse type class and the sign-extended immediate.
module rv_instr_decode
  import imem_fetch_decoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_fields_t fields_o
);

  // Slice fixed fields from the raw word, then classify by opcode
  always_comb begin
    fields_o         = '0;
    fields_o.opcode  = instr_i[6:0];
    fields_o.rd      = instr_i[11:7];
    fields_o.funct3  = instr_i[14:12];
    fields_o.rs1     = instr_i[19:15];
    fields_o.rs2     = instr_i[24:20];
    fields_o.funct7  = instr_i[31:25];
    fields_o.imm     = 32'h0;
    fields_o.dtype   = DT_OTHER;
    fields_o.illegal = 1'b0;
    case (instr_i[6:0])
      OPC_R: begin
        fields_o.dtype = DT_R;
      end
      OPC_I: begin
        fields_o.dtype = DT_I;
        fields_o.imm   = sext12(instr_i[31:20]);
      end
      OPC_L: begin
        fields_o.dtype = DT_LOAD;
        fields_o.imm   = sext12(instr_i[31:20]);
      end
      OPC_S: begin
        fields_o.dtype = DT_STORE;
        fields_o.imm   = sext12({instr_i[31:25], instr_i[11:7]});
      end
      OPC_JAL: begin
        fields_o.dtype = DT_JAL;
        fields_o.imm   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      end
      default: begin
        fields_o.dtype   = DT_OTHER;
        fields_o.illegal = 1'b1;
        fields_o.imm     = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/imem_fetch_decoder.sv
// Sequential fetcher: reads words from instruction memory starting at
// START_ADDR, decodes each one and offers it on a valid/ready port until the
// halt word is seen or MAX_WORDS words have been handed over.
module imem_fetch_decoder #(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_re,
  output logic [31:0] imem_raddr,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7,
  output logic [31:0] dec_imm,
  output logic [2:0]  dec_type,
  output logic [0:0]  dec_illegal,
  output logic        busy,
  output logic        done
);
  import imem_fetch_decoder_pkg::*;

  localparam logic [7:0] LAST_COUNT = 8'(MAX_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [7:0]   count_q, count_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         re_q, re_d;
  logic [31:0]  raddr_q, raddr_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  dpc_q, dpc_d;
  dec_fields_t  fields_q, fields_d;
  dec_fields_t  dec_s;

  rv_instr_decode u_decode (
    .instr_i  (imem_rdata),
    .fields_o (dec_s)
  );

  // Next-state and registered-output computation for the fetch FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = done_q;
    re_d     = 1'b0;
    raddr_d  = raddr_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    dpc_d    = dpc_q;
    fields_d = fields_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_ADDR;
          count_d = 8'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          re_d    = 1'b1;
          raddr_d = START_ADDR;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // read data is only valid in this cycle, so latch word and decode now
        instr_d  = imem_rdata;
        fields_d = dec_s;
        dpc_d    = pc_q;
        valid_d  = 1'b1;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (dec_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          if ((instr_q == HALT_WORD) || (count_d == LAST_COUNT)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            pc_d    = pc_q + 32'd4;
            re_d    = 1'b1;
            raddr_d = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; low rst clears everything on the next edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 32'h0;
      count_q  <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      re_q     <= 1'b0;
      raddr_q  <= 32'h0;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      dpc_q    <= 32'h0;
      fields_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      re_q     <= re_d;
      raddr_q  <= raddr_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      dpc_q    <= dpc_d;
      fields_q <= fields_d;
    end
  end

  assign imem_re     = re_q;
  assign imem_raddr  = raddr_q;
  assign dec_valid   = valid_q;
  assign dec_pc      = dpc_q;
  assign dec_opcode  = fields_q.opcode;
  assign dec_rd      = fields_q.rd;
  assign dec_rs1     = fields_q.rs1;
  assign dec_rs2     = fields_q.rs2;
  assign dec_funct3  = fields_q.funct3;
  assign dec_funct7  = fields_q.funct7;
  assign dec_imm     = fields_q.imm;
  assign dec_type    = fields_q.dtype;
  assign dec_illegal = fields_q.illegal;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_imem_fetch_decoder.sv
// Randomized bench for imem_fetch_decoder with a transaction-level model:
// each run is the list of words at START, START+4, ... up to the halt word or
// the word limit; decode values come from arithmetic on the raw word.
module tb_imem_fetch_decoder;

  localparam logic [31:0] START = 32'h0;
  localparam int          MAXW  = 3;
  localparam logic [31:0] HALT  = 32'h0000006F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dec_ready = 1'b0;
  logic        imem_re;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [31:0] dec_imm;
  logic [2:0]  dec_type;
  logic [0:0]  dec_illegal;
  logic        busy, done;

  always #5 clk = ~clk;

  imem_fetch_decoder #(.START_ADDR(START), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_re(imem_re), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_opcode(dec_opcode), .dec_rd(dec_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_funct3(dec_funct3),
    .dec_funct7(dec_funct7), .dec_imm(dec_imm), .dec_type(dec_type),
    .dec_illegal(dec_illegal), .busy(busy), .done(done)
  );

  // Instruction memory: data one cycle after the strobe, garbage otherwise
  logic [31:0] mem [0:3];
  always @(posedge clk) imem_rdata <= imem_re ? mem[imem_raddr[3:2]] : $urandom;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } rec_t;

  rec_t got_q[$];
  int total = 0;
  int bad = 0;

  function automatic rec_t model_dec(input logic [31:0] w, input logic [31:0] pc);
    rec_t r;
    int   s;
    s     = w;
    r.pc  = pc;
    r.opc = 7'(w % 128);
    r.rd  = 5'((w >> 7) % 32);
    r.f3  = 3'((w >> 12) % 8);
    r.rs1 = 5'((w >> 15) % 32);
    r.rs2 = 5'((w >> 20) % 32);
    r.f7  = 7'(w >> 25);
    r.imm = 32'h0;
    r.typ = 3'd7;
    r.ill = 1'b0;
    case (r.opc)
      7'h33: r.typ = 3'd0;
      7'h13: begin r.typ = 3'd1; r.imm = 32'(s >>> 20); end
      7'h03: begin r.typ = 3'd2; r.imm = 32'(s >>> 20); end
      7'h23: begin r.typ = 3'd3; r.imm = 32'((s >>> 25) * 32 + int'((w >> 7) % 32)); end
      7'h6F: begin
        r.typ = 3'd4;
        r.imm = 32'((w[31] ? -1048576 : 0) + int'((w >> 12) % 256) * 4096
                    + int'((w >> 20) % 2) * 2048 + int'((w >> 21) % 1024) * 2);
      end
      default: begin r.typ = 3'd7; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  // Run-level model: busy/done, words handed over, and read/offer timing
  logic        m_busy = 1'b0, m_done = 1'b0, m_fin = 1'b0, m_valid = 1'b0;
  int          m_cnt = 0, m_delay = 0;
  logic [31:0] m_pc, m_word;
  assign m_pc   = START + 32'(m_cnt) * 32'd4;
  assign m_word = mem[m_pc[3:2]];

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_fin <= 1'b0; m_valid <= 1'b0;
      m_cnt <= 0; m_delay <= 0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_done <= 1'b0; m_cnt <= 0; m_delay <= 2;
      end
    end else if (m_valid) begin
      if (dec_ready) begin
        m_valid <= 1'b0;
        m_cnt   <= m_cnt + 1;
        if (m_word == HALT || m_cnt + 1 == MAXW) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_fin <= 1'b1;
        end else begin
          m_delay <= 2;
        end
      end
    end else begin
      if (m_delay == 1) m_valid <= 1'b1;
      m_delay <= m_delay - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    rec_t e, a;
    logic re_exp;
    re_exp = m_busy && !m_valid && (m_delay == 2);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("dec_valid", 32'(dec_valid), 32'(m_valid));
    chk("imem_re", 32'(imem_re), 32'(re_exp));
    if (re_exp) chk("imem_raddr", imem_raddr, m_pc);
    if (m_valid) begin
      e = model_dec(m_word, m_pc);
      a = '{dec_pc, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_funct3, dec_funct7,
            dec_imm, dec_type, dec_illegal[0]};
      chk("dec_pc", a.pc, e.pc);
      chk("dec_opcode", 32'(a.opc), 32'(e.opc));
      chk("dec_rd", 32'(a.rd), 32'(e.rd));
      chk("dec_rs1", 32'(a.rs1), 32'(e.rs1));
      chk("dec_rs2", 32'(a.rs2), 32'(e.rs2));
      chk("dec_funct3", 32'(a.f3), 32'(e.f3));
      chk("dec_funct7", 32'(a.f7), 32'(e.f7));
      chk("dec_imm", a.imm, e.imm);
      chk("dec_type", 32'(a.typ), 32'(e.typ));
      chk("dec_illegal", 32'(a.ill), 32'(e.ill));
      if (dec_ready) got_q.push_back(a);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                     input int ready_pct, input bit hold, output int base);
    int cyc, held;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = $urandom;
    base = got_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    held = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (hold && dec_valid && held < 10) begin
        dec_ready = 1'b0;
        held++;
      end else begin
        dec_ready = ($urandom_range(99) < ready_pct);
      end
      start = ($urandom_range(9) == 0);
      step();
      cyc++;
    end
    start = 1'b0;
    dec_ready = 1'b0;
    if (cyc >= 300) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done after %0d cycles, required done=1", cyc);
    end
    step();
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(9))
      0: w = HALT;
      1: w[6:0] = 7'h33;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h03;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h6F;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   b;
    rec_t r;
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    repeat (3) step();

    // reset state
    chk("rst_imem_re", 32'(imem_re), 32'd0);
    chk("rst_raddr", imem_raddr, 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_imm", dec_imm, 32'd0);

    // pin the model against hand-computed immediates
    r = model_dec(32'h0040006F, 32'h0);
    chk("model_jal4", r.imm, 32'd4);
    r = model_dec(32'h8000006F, 32'h0);
    chk("model_jalneg", r.imm, 32'hFFF00000);
    r = model_dec(32'h00B02223, 32'h0);
    chk("model_store", r.imm, 32'd4);

    rst = 1'b1;
    step();

    // ADDI x9,x0,5 then halt; consumer stalls 10 cycles on the first word
    run(32'h00500493, HALT, 32'h0, 100, 1'b1, b);
    chk("A_count", 32'(got_q.size() - b), 32'd2);
    chk("A_done", 32'(done), 32'd1);
    if (got_q.size() - b == 2) begin
      chk("A0_pc", got_q[b].pc, 32'd0);
      chk("A0_type", 32'(got_q[b].typ), 32'd1);
      chk("A0_rd", 32'(got_q[b].rd), 32'd9);
      chk("A0_rs1", 32'(got_q[b].rs1), 32'd0);
      chk("A0_imm", got_q[b].imm, 32'd5);
      chk("A1_pc", got_q[b+1].pc, 32'd4);
      chk("A1_type", 32'(got_q[b+1].typ), 32'd4);
      chk("A1_imm", got_q[b+1].imm, 32'd0);
    end

    // no halt word: stops after the word limit
    run(32'h40A485B3, 32'h00B02223, 32'h00402603, 100, 1'b0, b);
    chk("B_count", 32'(got_q.size() - b), 32'd3);
    chk("B_done", 32'(done), 32'd1);
    if (got_q.size() - b == 3) begin
      chk("B0_type", 32'(got_q[b].typ), 32'd0);
      chk("B0_rd", 32'(got_q[b].rd), 32'd11);
      chk("B0_rs1", 32'(got_q[b].rs1), 32'd9);
      chk("B0_rs2", 32'(got_q[b].rs2), 32'd10);
      chk("B0_f7", 32'(got_q[b].f7), 32'h20);
      chk("B0_f3", 32'(got_q[b].f3), 32'd0);
      chk("B0_imm", got_q[b].imm, 32'd0);
      chk("B1_type", 32'(got_q[b+1].typ), 32'd3);
      chk("B1_rs2", 32'(got_q[b+1].rs2), 32'd11);
      chk("B1_imm", got_q[b+1].imm, 32'd4);
      chk("B2_type", 32'(got_q[b+2].typ), 32'd2);
      chk("B2_rd", 32'(got_q[b+2].rd), 32'd12);
      chk("B2_f3", 32'(got_q[b+2].f3), 32'd2);
      chk("B2_imm", got_q[b+2].imm, 32'd4);
    end

    // negative immediate and an illegal word
    run(32'hFFF00493, 32'hFFFFFFFF, HALT, 50, 1'b0, b);
    chk("C_count", 32'(got_q.size() - b), 32'd3);
    if (got_q.size() - b == 3) begin
      chk("C0_imm", got_q[b].imm, 32'hFFFFFFFF);
      chk("C1_type", 32'(got_q[b+1].typ), 32'd7);
      chk("C1_illegal", 32'(got_q[b+1].ill), 32'd1);
    end

    // reset while the first read is in flight
    mem[0] = 32'h00500493; mem[1] = HALT;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("R_valid", 32'(dec_valid), 32'd0);
    chk("R_busy", 32'(busy), 32'd0);
    chk("R_done", 32'(done), 32'd0);
    chk("R_pc", dec_pc, 32'd0);
    chk("R_imm", dec_imm, 32'd0);
    chk("R_type", 32'(dec_type), 32'd0);
    repeat (4) step();
    run(32'h00500493, HALT, 32'h0, 100, 1'b0, b);
    chk("R2_count", 32'(got_q.size() - b), 32'd2);
    if (got_q.size() - b == 2) chk("R2_pc", got_q[b].pc, START);

    // randomized runs with occasional mid-run reset
    for (int it = 0; it < 40; it++) begin
      if (it % 9 == 4) begin
        mem[0] = rand_word(); mem[1] = rand_word(); mem[2] = rand_word();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat ($urandom_range(8)) begin
          dec_ready = $urandom_range(1);
          step();
        end
        dec_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
      end else begin
        run(rand_word(), rand_word(), rand_word(), 30 + $urandom_range(70), it[0], b);
      end
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
